mac_term_sequencer: RTL and testbench
=====================================

Name: mac_term_sequencer

Overview:
- Upstream feeder for the product-sum MAC stage.
- Holds the polynomial coefficients a0..a(N-1) in a small register file and latches an 8-bit operand x on start.
- Streams one (ai, xi = x^i mod 256) pair per clock and drives the MAC's enable, valid_in and done controls.
- A quadratic a2*x^2 + a1*x + a0 is accumulated with no external sequencing; result_ready flags the cycle in which the MAC result holds the final sum.

Parameters:
N_TERMS, 3, number of terms streamed per evaluation (1..2^ADDR_W)
ADDR_W, 2, coefficient address width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
coef_wr  input  1  coefficient write strobe
coef_addr  input  ADDR_W  coefficient index
coef_data  input  8  coefficient value
start  input  1  begin evaluation; sampled only in IDLE
x_in  input  8  operand x, latched when start is accepted
ai_out  output  8  coefficient to MAC in_ai
xi_out  output  8  power of x to MAC in_xi
valid_out  output  1  to MAC valid_in
enable_out  output  1  to MAC enable
done_out  output  1  to MAC done
busy  output  1  high in every state except IDLE
result_ready  output  1  one-cycle pulse: MAC result holds the final sum

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous): state IDLE; coefficient registers, x register, power register and term counter are 0; every output is 0.
- Coefficient write: in IDLE only. coef_wr=1 with coef_addr<N_TERMS writes coef_data at the clock edge. Writes with coef_addr>=N_TERMS or busy=1 are ignored.
- In IDLE, start and coef_wr in the same cycle: the write takes effect and the evaluation uses the new value.
- States: IDLE -> RUN -> FLUSH -> CLEAR -> REPORT -> IDLE.
- IDLE:
  - enable_out=0, valid_out=0, done_out=0.
  - start=1 at edge k: latch x_in, power<=1, cnt<=0, go RUN.
- RUN:
  - Holds for N_TERMS cycles, one per term i = 0..N_TERMS-1.
  - Term i: enable_out=1, valid_out=1, ai_out=coef[i], xi_out=x^i mod 256. Term 0 carries xi=1 and is visible in the cycle after edge k.
  - Next power = low 8 bits of (power*x); the 16-bit product is truncated and the wrap is silent.
  - After term N_TERMS-1, go FLUSH.
- FLUSH (1 cycle): enable_out=1, valid_out=0, done_out=0, ai_out=xi_out=0. The MAC absorbs its last registered product.
- CLEAR (1 cycle): enable_out=1, valid_out=0, done_out=1. The MAC result register captures the final sum and its accumulator clears.
- REPORT (1 cycle): enable_out=0, result_ready=1. The MAC result equals sum(ai*xi) mod 2^16. Go IDLE.
- Latency: start accepted at edge k -> result_ready high in cycle k+N_TERMS+3, counting cycle k+1 as the first RUN cycle.
- start while busy=1 is ignored; no queueing.
- start held high: a new evaluation begins in the cycle after REPORT. Back-to-back evaluations therefore have a one-IDLE-cycle gap.
- Reset mid-operation: immediate return to IDLE with all outputs 0. Stored coefficients are also cleared.
- N_TERMS=1: RUN lasts 1 cycle with xi=1.

Test Plan:
- Reset during idle and during RUN -> every output reads 0 while reset=0; busy=0; after release, valid_out stays 0 until start.
- Write a0=3, a1=2, a2=1; start with x=4 -> RUN pairs (3,1), (2,4), (1,16); then FLUSH, CLEAR with done_out=1, and REPORT; result_ready high 6 cycles after the start edge; MAC result=27.
- x=20, coefficients 1,1,1 -> xi sequence 1, 20, 144 (400 mod 256); MAC result=165.
- Pulse start again during RUN, and attempt a coef_wr to address 0 during RUN -> no restart, coefficient unchanged, second run gives an identical result.
- coef_wr to address 3 with N_TERMS=3 -> ignored; readback via a run with x=2 and coefficients 5,0,0 gives result 5.
- start held high for 20 cycles with a0..a2=255 and x=255 -> repeated evaluations with a one-cycle IDLE gap; xi sequence 1, 255, 1 (65025 mod 256); result = (255 + 65025 + 255) mod 65536 = 65535, i.e. 0xFFFF, in each REPORT cycle.

Source files
------------

// File: rtl/mac_term_sequencer.sv
// Feeds the product-sum MAC one (coefficient, x^i) pair per clock and drives its
// enable/valid/done controls; result_ready marks the cycle the MAC result is final.
module mac_term_sequencer #(
    parameter int N_TERMS = 3,
    parameter int ADDR_W  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              coef_wr,
    input  logic [ADDR_W-1:0] coef_addr,
    input  logic [7:0]        coef_data,
    input  logic              start,
    input  logic [7:0]        x_in,
    output logic [7:0]        ai_out,
    output logic [7:0]        xi_out,
    output logic              valid_out,
    output logic              enable_out,
    output logic              done_out,
    output logic              busy,
    output logic              result_ready
);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_CLEAR,
        ST_REPORT
    } state_t;

    state_t      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [7:0]  x_reg, x_next;
    logic [7:0]  pow_reg, pow_next;
    logic [7:0]  ai_next, xi_next;
    logic        valid_next, enable_next, done_next, busy_next, ready_next;
    logic [7:0]  coef_reg [DEPTH];
    logic        wr_ok;
    logic [15:0] prod;

    assign wr_ok = coef_wr && (state_reg == ST_IDLE) &&
                   ({1'b0, coef_addr} < CNT_W'(N_TERMS));
    assign prod  = 16'(pow_reg) * 16'(x_reg);

    // Entries at or above N_TERMS are never written and stay zero.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_coef
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    coef_reg[gi] <= 8'd0;
                end else if (wr_ok && (coef_addr == ADDR_W'(gi)) && (gi < N_TERMS)) begin
                    coef_reg[gi] <= coef_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            x_reg        <= 8'd0;
            pow_reg      <= 8'd0;
            ai_out       <= 8'd0;
            xi_out       <= 8'd0;
            valid_out    <= 1'b0;
            enable_out   <= 1'b0;
            done_out     <= 1'b0;
            busy         <= 1'b0;
            result_ready <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            x_reg        <= x_next;
            pow_reg      <= pow_next;
            ai_out       <= ai_next;
            xi_out       <= xi_next;
            valid_out    <= valid_next;
            enable_out   <= enable_next;
            done_out     <= done_next;
            busy         <= busy_next;
            result_ready <= ready_next;
        end
    end

    // Outputs are computed one cycle ahead so they appear registered in the
    // state they belong to. pow_reg always holds the power for the next term.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        x_next      = x_reg;
        pow_next    = pow_reg;
        ai_next     = 8'd0;
        xi_next     = 8'd0;
        valid_next  = 1'b0;
        enable_next = 1'b0;
        done_next   = 1'b0;
        busy_next   = 1'b1;
        ready_next  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy_next = 1'b0;
                if (start) begin
                    state_next  = ST_RUN;
                    x_next      = x_in;
                    pow_next    = x_in;
                    cnt_next    = CNT_W'(1);
                    // A same-cycle write to address 0 must reach term 0.
                    ai_next     = (wr_ok && coef_addr == '0) ? coef_data : coef_reg[0];
                    xi_next     = 8'd1;
                    valid_next  = 1'b1;
                    enable_next = 1'b1;
                    busy_next   = 1'b1;
                end
            end
            ST_RUN: begin
                enable_next = 1'b1;
                if (cnt_reg < CNT_W'(N_TERMS)) begin
                    ai_next    = coef_reg[cnt_reg[ADDR_W-1:0]];
                    xi_next    = pow_reg;
                    pow_next   = prod[7:0];
                    cnt_next   = cnt_reg + CNT_W'(1);
                    valid_next = 1'b1;
                end else begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_next  = ST_CLEAR;
                enable_next = 1'b1;
                done_next   = 1'b1;
            end
            ST_CLEAR: begin
                state_next = ST_REPORT;
                ready_next = 1'b1;
            end
            ST_REPORT: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_mac_term_sequencer.sv
// Directed bench for mac_term_sequencer: vector table of evaluations plus
// hand-written sequences for same-cycle writes, busy-time pokes, held start and reset.
module tb_mac_term_sequencer;
    localparam int N = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       coef_wr;
    logic [1:0] coef_addr;
    logic [7:0] coef_data;
    logic       start;
    logic [7:0] x_in;
    logic [7:0] ai_out, xi_out;
    logic       valid_out, enable_out, done_out, busy, result_ready;

    int n_cmp = 0;
    int n_bad = 0;

    mac_term_sequencer #(.N_TERMS(N), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .start(start), .x_in(x_in),
        .ai_out(ai_out), .xi_out(xi_out),
        .valid_out(valid_out), .enable_out(enable_out), .done_out(done_out),
        .busy(busy), .result_ready(result_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  c [3];
        logic [7:0]  x;
        logic [7:0]  xi [3];
        logic [15:0] res;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk(name, {ai_out, xi_out, valid_out, enable_out, done_out, busy, result_ready}, 32'd0);
    endtask

    task automatic set_vec(input int i, input logic [7:0] c0, c1, c2, x,
                           input logic [7:0] x0, x1, x2, input logic [15:0] res);
        tbl[i].c[0] = c0; tbl[i].c[1] = c1; tbl[i].c[2] = c2; tbl[i].x = x;
        tbl[i].xi[0] = x0; tbl[i].xi[1] = x1; tbl[i].xi[2] = x2; tbl[i].res = res;
    endtask

    task automatic load(input logic [7:0] c0, c1, c2);
        logic [7:0] cv [4];
        cv[0] = c0; cv[1] = c1; cv[2] = c2; cv[3] = 8'hAA;
        for (int a = 0; a < 4; a++) begin
            @(negedge clk);
            coef_wr = 1'b1; coef_addr = 2'(a); coef_data = cv[a];
        end
        @(negedge clk);
        coef_wr = 1'b0;
    endtask

    // Drives start in IDLE and checks every cycle through REPORT; the bench
    // accumulates ai*xi over valid cycles as a stand-in for the MAC.
    task automatic run_eval(input string tag, input logic [7:0] x,
                            input logic [7:0] e_ai [3], input logic [7:0] e_xi [3],
                            input logic [15:0] e_res, input bit hold,
                            input bit wr0, input logic [7:0] wr0_data, input bit poke);
        logic [15:0] acc;
        acc = 16'd0;
        @(negedge clk);
        chk({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
        start = 1'b1; x_in = x;
        if (wr0) begin
            coef_wr = 1'b1; coef_addr = 2'd0; coef_data = wr0_data;
        end
        for (int c = 1; c <= N + 3; c++) begin
            @(negedge clk);
            if (c <= N) begin
                chk($sformatf("%s run%0d_ctl", tag, c - 1),
                    {27'd0, busy, enable_out, valid_out, done_out, result_ready}, 32'b11100);
                chk($sformatf("%s run%0d_ai", tag, c - 1), {24'd0, ai_out}, {24'd0, e_ai[c-1]});
                chk($sformatf("%s run%0d_xi", tag, c - 1), {24'd0, xi_out}, {24'd0, e_xi[c-1]});
            end else if (c == N + 1) begin
                chk({tag, " flush_ctl"},
                    {27'd0, busy, enable_out, valid_out, done_out, result_ready}, 32'b11000);
                chk({tag, " flush_data"}, {16'd0, ai_out, xi_out}, 32'd0);
            end else if (c == N + 2) begin
                chk({tag, " clear_ctl"},
                    {27'd0, busy, enable_out, valid_out, done_out, result_ready}, 32'b11010);
            end else begin
                chk({tag, " report_ctl"},
                    {27'd0, busy, enable_out, valid_out, done_out, result_ready}, 32'b10001);
                chk({tag, " result"}, {16'd0, acc}, {16'd0, e_res});
            end
            if (valid_out) acc = acc + ai_out * xi_out;
            if (c == 1) begin
                if (!hold) start = 1'b0;
                coef_wr = 1'b0;
            end
            if (poke && c == 2) begin
                start = 1'b1; coef_wr = 1'b1; coef_addr = 2'd0; coef_data = 8'd99;
            end
            if (poke && c == 3) begin
                start = 1'b0; coef_wr = 1'b0;
            end
        end
        $display("eval %s: x=%0d result=%0d expected=%0d", tag, x, acc, e_res);
    endtask

    logic [7:0] eai [3];
    logic [7:0] exi [3];

    initial begin
        reset = 1'b0; coef_wr = 1'b0; coef_addr = 2'd0; coef_data = 8'd0;
        start = 1'b0; x_in = 8'd0;

        set_vec(0,   3,   2,   1,   4, 1,  4,  16, 16'd27);
        set_vec(1,   1,   1,   1,  20, 1, 20, 144, 16'd165);
        set_vec(2,   5,   0,   0,   2, 1,  2,   4, 16'd5);
        set_vec(3,   0,   0,   7,  16, 1, 16,   0, 16'd0);
        set_vec(4, 255, 255, 255, 255, 1, 255,  1, 16'd65535);
        set_vec(5,  10,   3,   2,   0, 1,  0,   0, 16'd10);

        @(negedge clk);
        start = 1'b1; x_in = 8'd9;
        @(negedge clk);
        chk_zero("reset_idle_outputs");
        start = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_reset_quiet%0d", i), {30'd0, valid_out, busy}, 32'd0);
        end

        for (int v = 0; v < 6; v++) begin
            load(tbl[v].c[0], tbl[v].c[1], tbl[v].c[2]);
            run_eval($sformatf("vec%0d", v), tbl[v].x, tbl[v].c, tbl[v].xi,
                     tbl[v].res, 1'b0, 1'b0, 8'd0, 1'b0);
        end

        // start with a same-cycle write to a0: term 0 must use the new value
        load(8'd3, 8'd2, 8'd1);
        eai[0] = 8'd7; eai[1] = 8'd2; eai[2] = 8'd1;
        exi[0] = 8'd1; exi[1] = 8'd4; exi[2] = 8'd16;
        run_eval("same_cycle_wr", 8'd4, eai, exi, 16'd31, 1'b0, 1'b1, 8'd7, 1'b0);

        // start and coef_wr during RUN are ignored
        run_eval("poke_run", 8'd4, eai, exi, 16'd31, 1'b0, 1'b0, 8'd0, 1'b1);
        run_eval("after_poke", 8'd4, eai, exi, 16'd31, 1'b0, 1'b0, 8'd0, 1'b0);

        // start held high: back-to-back evaluations with one IDLE gap
        load(8'd255, 8'd255, 8'd255);
        eai[0] = 8'd255; eai[1] = 8'd255; eai[2] = 8'd255;
        exi[0] = 8'd1;   exi[1] = 8'd255; exi[2] = 8'd1;
        for (int r = 0; r < 3; r++)
            run_eval($sformatf("held%0d", r), 8'd255, eai, exi, 16'hFFFF, 1'b1, 1'b0, 8'd0, 1'b0);
        @(negedge clk);
        chk("held_gap_idle", {30'd0, valid_out, busy}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        chk("held_released_idle", {30'd0, valid_out, busy}, 32'd0);

        // reset in the middle of RUN clears outputs and coefficients
        load(8'd3, 8'd2, 8'd1);
        @(negedge clk);
        start = 1'b1; x_in = 8'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_reset_running", {31'd0, valid_out}, 32'd1);
        reset = 1'b0;
        #1;
        chk_zero("reset_mid_run_async");
        @(negedge clk);
        chk_zero("reset_mid_run_held");
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("post_mid_reset_quiet%0d", i), {30'd0, valid_out, busy}, 32'd0);
        end
        eai[0] = 8'd0; eai[1] = 8'd0; eai[2] = 8'd0;
        exi[0] = 8'd1; exi[1] = 8'd4; exi[2] = 8'd16;
        run_eval("coefs_cleared", 8'd4, eai, exi, 16'd0, 1'b0, 1'b0, 8'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
